// File: rtl/ray_setup_pipe.sv
// ray_setup_pipe
//   Per-column ray setup ahead of the DDA stage. For one screen column it
//   derives the camera-space x, the ray direction, the step signs, the map
//   cell, |1/rayDir| delta distances and the initial side distances.
//   One request is in flight at a time. The result is registered and held
//   until the DDA stage accepts it.
//
// Ports
//   pixel_clk_in, rst_in          clock, asynchronous active-high reset
//   in_valid / in_ready           request handshake
//   hcount_in                     column index 0..SCREEN_WIDTH-1
//   posX, posY                    unsigned player position, Q(WIDTH-FBITS).FBITS
//   dirX, dirY, planeX, planeY    signed direction and camera plane
//   out_valid / out_ready         result handshake
//   hcount_out                    column the result belongs to
//   rayDirX, rayDirY              signed saturated ray direction
//   stepX, stepY                  1 = +1, 0 = -1
//   mapX, mapY                    integer map cell of the position
//   deltaDistX, deltaDistY        unsigned |1/rayDir|, saturated
//   sideDistX, sideDistY          unsigned initial side distance, saturated
//   dbzX, dbzY                    ray component was zero
//   busy                          request in flight or result held
module ray_setup_pipe #(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned FBITS        = 8,
  parameter int unsigned SCREEN_WIDTH = 320,
  parameter int unsigned HCOUNT_W     = 9,
  parameter int unsigned MAP_W        = 7
) (
  input  logic                pixel_clk_in,
  input  logic                rst_in,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [HCOUNT_W-1:0] hcount_in,
  input  logic [WIDTH-1:0]    posX,
  input  logic [WIDTH-1:0]    posY,
  input  logic [WIDTH-1:0]    dirX,
  input  logic [WIDTH-1:0]    dirY,
  input  logic [WIDTH-1:0]    planeX,
  input  logic [WIDTH-1:0]    planeY,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [HCOUNT_W-1:0] hcount_out,
  output logic [WIDTH-1:0]    rayDirX,
  output logic [WIDTH-1:0]    rayDirY,
  output logic                stepX,
  output logic                stepY,
  output logic [MAP_W-1:0]    mapX,
  output logic [MAP_W-1:0]    mapY,
  output logic [WIDTH-1:0]    deltaDistX,
  output logic [WIDTH-1:0]    deltaDistY,
  output logic [WIDTH-1:0]    sideDistX,
  output logic [WIDTH-1:0]    sideDistY,
  output logic                dbzX,
  output logic                dbzY,
  output logic                busy
);

  // Quotient of 2^(2*FBITS) / |rayDir| needs 2*FBITS+1 bits.
  localparam int unsigned QW    = 2 * FBITS + 1;
  localparam int unsigned CNT_W = $clog2(QW + 1);
  // Signed working width for the camera / ray arithmetic.
  localparam int unsigned CW    = 2 * WIDTH + HCOUNT_W + 4;
  localparam int unsigned CAM_K = (2 ** (2 * FBITS) + SCREEN_WIDTH / 2) / SCREEN_WIDTH;

  localparam logic [WIDTH-1:0]     UMAX     = '1;
  localparam logic signed [CW-1:0] SMAX     = {{(CW - WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
  localparam logic signed [CW-1:0] SMIN     = ~SMAX;
  localparam logic signed [CW-1:0] SCREEN_S = CW'(SCREEN_WIDTH);
  localparam logic signed [CW-1:0] CAM_S    = CW'(CAM_K);
  localparam logic signed [CW-1:0] ROUND_S  = CW'(1) <<< (FBITS - 1);
  localparam logic signed [CW-1:0] TWO_S    = CW'(2);

  typedef enum logic [2:0] {StIdle, StRaydir, StDivide, StSide, StHold} state_e;

  state_e state_q, state_d;

  // Captured request
  logic [HCOUNT_W-1:0]     h_q;
  logic [WIDTH-1:0]        pos_x_q, pos_y_q;
  logic signed [WIDTH-1:0] dir_x_q, dir_y_q, plane_x_q, plane_y_q;

  // Ray direction and divider state
  logic signed [WIDTH-1:0] ray_x_q, ray_y_q;
  logic [WIDTH-1:0]        mag_x_q, mag_y_q;
  logic [WIDTH-1:0]        rem_x_q, rem_y_q;
  logic [QW-1:0]           quo_x_q, quo_y_q;
  logic                    zero_x_q, zero_y_q;
  logic [CNT_W-1:0]        cnt_q;

  logic                    accept;
  logic signed [CW-1:0]    cam_x;
  logic signed [WIDTH-1:0] ray_x_c, ray_y_c;
  logic [WIDTH:0]          step_x_c, step_y_c;
  logic                    div_bit;
  logic [WIDTH-1:0]        delta_x_c, delta_y_c, side_x_c, side_y_c;

  // ray = dir + ((plane * cam) >>> FBITS), clamped to the signed WIDTH range.
  function automatic logic signed [WIDTH-1:0] ray_of(input logic signed [WIDTH-1:0] dir,
                                                     input logic signed [WIDTH-1:0] plane,
                                                     input logic signed [CW-1:0]    cam);
    logic signed [CW-1:0] prod;
    logic signed [CW-1:0] sum;
    prod = (CW'(plane) * cam) >>> FBITS;
    sum  = CW'(dir) + prod;
    if (sum > SMAX) begin
      return SMAX[WIDTH-1:0];
    end else if (sum < SMIN) begin
      return SMIN[WIDTH-1:0];
    end
    return sum[WIDTH-1:0];
  endfunction

  // Magnitude; the most negative value maps to 2^(WIDTH-1) as an unsigned result.
  function automatic logic [WIDTH-1:0] mag_of(input logic signed [WIDTH-1:0] v);
    logic [WIDTH-1:0] u;
    u = v;
    return v[WIDTH-1] ? (~u + 1'b1) : u;
  endfunction

  // One restoring-division step: returns {quotient bit, next remainder}.
  // The remainder stays below the divisor, so WIDTH bits hold it.
  function automatic logic [WIDTH:0] div_step(input logic [WIDTH-1:0] rem,
                                              input logic [WIDTH-1:0] mag,
                                              input logic             bit_in);
    logic [WIDTH:0] sh;
    logic [WIDTH:0] sub;
    sh  = {rem, bit_in};
    sub = sh - {1'b0, mag};
    if (sh >= {1'b0, mag}) begin
      return {1'b1, sub[WIDTH-1:0]};
    end
    return {1'b0, sh[WIDTH-1:0]};
  endfunction

  function automatic logic [WIDTH-1:0] delta_of(input logic [QW-1:0] quo, input logic zero);
    if (zero || ((QW + WIDTH)'(quo) > (QW + WIDTH)'(UMAX))) begin
      return UMAX;
    end
    return WIDTH'(quo);
  endfunction

  // Distance to the first grid line: fractional part toward the step direction.
  function automatic logic [WIDTH-1:0] side_of(input logic [FBITS-1:0] f,
                                               input logic             step,
                                               input logic [WIDTH-1:0] delta);
    logic [FBITS:0]       w;
    logic [FBITS+WIDTH:0] p;
    w = step ? (((FBITS + 1)'(1) << FBITS) - {1'b0, f}) : {1'b0, f};
    p = w * delta;
    if (p[FBITS+WIDTH]) begin
      return UMAX;
    end
    return p[FBITS+WIDTH-1:FBITS];
  endfunction

  // cameraX = ((2*h - SCREEN_WIDTH) * CAM_K + half) >>> FBITS, flooring on negatives.
  assign cam_x = ((TWO_S * $signed({{(CW - HCOUNT_W){1'b0}}, h_q}) - SCREEN_S) * CAM_S + ROUND_S)
                 >>> FBITS;

  assign ray_x_c = ray_of(dir_x_q, plane_x_q, cam_x);
  assign ray_y_c = ray_of(dir_y_q, plane_y_q, cam_x);

  // The leading 1 of 2^(2*FBITS) enters on the first iteration; the rest are zeros.
  assign div_bit  = (cnt_q == CNT_W'(1));
  assign step_x_c = div_step(rem_x_q, mag_x_q, div_bit);
  assign step_y_c = div_step(rem_y_q, mag_y_q, div_bit);

  assign delta_x_c = delta_of(quo_x_q, zero_x_q);
  assign delta_y_c = delta_of(quo_y_q, zero_y_q);
  assign side_x_c  = side_of(pos_x_q[FBITS-1:0], ~ray_x_q[WIDTH-1], delta_x_c);
  assign side_y_c  = side_of(pos_y_q[FBITS-1:0], ~ray_y_q[WIDTH-1], delta_y_c);

  // Next-state and handshake
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) state_d = StRaydir;
      end
      StRaydir: state_d = StDivide;
      StDivide: begin
        if (cnt_q == CNT_W'(QW)) state_d = StSide;
      end
      StSide: state_d = StHold;
      StHold: begin
        // Retiring the held result frees the block for a new request this cycle.
        if (out_ready) begin
          in_ready = 1'b1;
          state_d  = in_valid ? StRaydir : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == StHold);
  assign busy      = (state_q != StIdle);

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Request capture and datapath
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      h_q       <= '0;
      pos_x_q   <= '0;
      pos_y_q   <= '0;
      dir_x_q   <= '0;
      dir_y_q   <= '0;
      plane_x_q <= '0;
      plane_y_q <= '0;
      ray_x_q   <= '0;
      ray_y_q   <= '0;
      mag_x_q   <= '0;
      mag_y_q   <= '0;
      rem_x_q   <= '0;
      rem_y_q   <= '0;
      quo_x_q   <= '0;
      quo_y_q   <= '0;
      zero_x_q  <= 1'b0;
      zero_y_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      if (accept) begin
        h_q       <= hcount_in;
        pos_x_q   <= posX;
        pos_y_q   <= posY;
        dir_x_q   <= dirX;
        dir_y_q   <= dirY;
        plane_x_q <= planeX;
        plane_y_q <= planeY;
      end
      case (state_q)
        StRaydir: begin
          ray_x_q <= ray_x_c;
          ray_y_q <= ray_y_c;
          cnt_q   <= '0;
        end
        StDivide: begin
          cnt_q <= cnt_q + CNT_W'(1);
          // Count 0 loads the divisors; counts 1..QW produce one quotient bit each.
          if (cnt_q == '0) begin
            mag_x_q  <= mag_of(ray_x_q);
            mag_y_q  <= mag_of(ray_y_q);
            zero_x_q <= (ray_x_q == '0);
            zero_y_q <= (ray_y_q == '0);
            rem_x_q  <= '0;
            rem_y_q  <= '0;
            quo_x_q  <= '0;
            quo_y_q  <= '0;
          end else begin
            rem_x_q <= step_x_c[WIDTH-1:0];
            rem_y_q <= step_y_c[WIDTH-1:0];
            quo_x_q <= {quo_x_q[QW-2:0], step_x_c[WIDTH]};
            quo_y_q <= {quo_y_q[QW-2:0], step_y_c[WIDTH]};
          end
        end
        default: ;
      endcase
    end
  end

  // Result registers, loaded once per request and held through HOLD
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      hcount_out <= '0;
      rayDirX    <= '0;
      rayDirY    <= '0;
      stepX      <= 1'b0;
      stepY      <= 1'b0;
      mapX       <= '0;
      mapY       <= '0;
      deltaDistX <= '0;
      deltaDistY <= '0;
      sideDistX  <= '0;
      sideDistY  <= '0;
      dbzX       <= 1'b0;
      dbzY       <= 1'b0;
    end else if (state_q == StSide) begin
      hcount_out <= h_q;
      rayDirX    <= ray_x_q;
      rayDirY    <= ray_y_q;
      stepX      <= ~ray_x_q[WIDTH-1];
      stepY      <= ~ray_y_q[WIDTH-1];
      mapX       <= MAP_W'(pos_x_q[WIDTH-1:FBITS]);
      mapY       <= MAP_W'(pos_y_q[WIDTH-1:FBITS]);
      deltaDistX <= delta_x_c;
      deltaDistY <= delta_y_c;
      sideDistX  <= side_x_c;
      sideDistY  <= side_y_c;
      dbzX       <= zero_x_q;
      dbzY       <= zero_y_q;
    end
  end

endmodule

// File: tb/tb_ray_setup_pipe.sv
module tb_ray_setup_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [8:0]  hcount_in, hcount_out;
  logic [15:0] posX, posY, dirX, dirY, planeX, planeY;
  logic [15:0] rayDirX, rayDirY, deltaDistX, deltaDistY, sideDistX, sideDistY;
  logic        stepX, stepY, dbzX, dbzY;
  logic [6:0]  mapX, mapY;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int rx, ry, sx, sy, dx, dy, ex, ey, zx, zy;
  } exp_t;

  ray_setup_pipe dut (
    .pixel_clk_in(clk),
    .rst_in      (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .hcount_in   (hcount_in),
    .posX        (posX),
    .posY        (posY),
    .dirX        (dirX),
    .dirY        (dirY),
    .planeX      (planeX),
    .planeY      (planeY),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .hcount_out  (hcount_out),
    .rayDirX     (rayDirX),
    .rayDirY     (rayDirY),
    .stepX       (stepX),
    .stepY       (stepY),
    .mapX        (mapX),
    .mapY        (mapY),
    .deltaDistX  (deltaDistX),
    .deltaDistY  (deltaDistY),
    .sideDistX   (sideDistX),
    .sideDistY   (sideDistY),
    .dbzX        (dbzX),
    .dbzY        (dbzY),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference arithmetic in plain integers (Q8.8, 320 columns, CAM_K = 205).
  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int delta_ref(input int ray);
    int m;
    m = (ray < 0) ? -ray : ray;
    if (m == 0) return 65535;
    if (65536 / m > 65535) return 65535;
    return 65536 / m;
  endfunction

  function automatic int side_ref(input int pos, input int step, input int delta);
    int f, s;
    f = pos & 255;
    s = step ? (((256 - f) * delta) >> 8) : ((f * delta) >> 8);
    return (s > 65535) ? 65535 : s;
  endfunction

  function automatic exp_t model(input int h, input int px, input int py, input int dx,
                                 input int dy, input int plx, input int ply);
    exp_t e;
    int   cam;
    cam  = ((2 * h - 320) * 205 + 128) >>> 8;
    e.rx = sat16(dx + ((plx * cam) >>> 8));
    e.ry = sat16(dy + ((ply * cam) >>> 8));
    e.sx = (e.rx >= 0) ? 1 : 0;
    e.sy = (e.ry >= 0) ? 1 : 0;
    e.dx = delta_ref(e.rx);
    e.dy = delta_ref(e.ry);
    e.ex = side_ref(px, e.sx, e.dx);
    e.ey = side_ref(py, e.sy, e.dy);
    e.zx = (e.rx == 0) ? 1 : 0;
    e.zy = (e.ry == 0) ? 1 : 0;
    return e;
  endfunction

  task automatic drive(input int h, input logic [15:0] px, input logic [15:0] py,
                       input logic [15:0] dx, input logic [15:0] dy,
                       input logic [15:0] plx, input logic [15:0] ply);
    hcount_in = 9'(h);
    posX      = px;
    posY      = py;
    dirX      = dx;
    dirY      = dy;
    planeX    = plx;
    planeY    = ply;
    in_valid  = 1'b1;
  endtask

  // Drop in_valid and garble the inputs so a result that depends on them shows up.
  task automatic scramble();
    in_valid  = 1'b0;
    hcount_in = 9'h1AB;
    posX      = 16'hDEAD;
    posY      = 16'hBEEF;
    dirX      = 16'h1234;
    dirY      = 16'h4321;
    planeX    = 16'h7777;
    planeY    = 16'h8888;
  endtask

  task automatic wait_valid(input string tag, input int exp_lat);
    int n;
    n = 0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (out_valid) begin
        n = i;
        break;
      end
    end
    check(tag, n, exp_lat);
  endtask

  task automatic check_out(input string tag, input int rx, input int ry, input int sx,
                           input int sy, input int dx, input int dy, input int ex,
                           input int ey, input int zx, input int zy);
    check({tag, ".rayDirX"}, 32'(rayDirX), 32'(rx & 32'hFFFF));
    check({tag, ".rayDirY"}, 32'(rayDirY), 32'(ry & 32'hFFFF));
    check({tag, ".stepX"}, 32'(stepX), 32'(sx));
    check({tag, ".stepY"}, 32'(stepY), 32'(sy));
    check({tag, ".deltaX"}, 32'(deltaDistX), 32'(dx));
    check({tag, ".deltaY"}, 32'(deltaDistY), 32'(dy));
    check({tag, ".sideX"}, 32'(sideDistX), 32'(ex));
    check({tag, ".sideY"}, 32'(sideDistY), 32'(ey));
    check({tag, ".dbzX"}, 32'(dbzX), 32'(zx));
    check({tag, ".dbzY"}, 32'(dbzY), 32'(zy));
  endtask

  task automatic retire(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, ".retire_valid"}, 32'(out_valid), 0);
    check({tag, ".retire_ready"}, 32'(in_ready), 1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".out_valid"}, 32'(out_valid), 0);
    check({tag, ".in_ready"}, 32'(in_ready), 1);
    check({tag, ".busy"}, 32'(busy), 0);
    check({tag, ".hcount"}, 32'(hcount_out), 0);
    check({tag, ".map"}, 32'({mapX, mapY}), 0);
    check_out(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    exp_t e;
    int   seen;

    rst       = 1'b1;
    out_ready = 1'b0;
    drive(0, '0, '0, '0, '0, '0, '0);
    in_valid  = 1'b0;
    #2;
    check_reset_state("reset");
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Centre column
    drive(160, 16'h0380, 16'h0240, 16'hFF00, 16'h0000, 16'h0000, 16'h00A9);
    check("centre.in_ready", 32'(in_ready), 1);
    tick();
    scramble();
    check("centre.busy", 32'(busy), 1);
    check("centre.in_ready_busy", 32'(in_ready), 0);
    wait_valid("centre.latency", 20);
    check("centre.hcount", 32'(hcount_out), 160);
    check("centre.mapX", 32'(mapX), 3);
    check("centre.mapY", 32'(mapY), 2);
    check_out("centre", 'hFF00, 0, 0, 1, 'h0100, 'hFFFF, 'h0080, 'hBFFF, 0, 1);
    retire("centre");

    // Left edge: cameraX = -256
    drive(0, 16'h0380, 16'h0240, 16'hFF00, 16'h0000, 16'h0000, 16'h00A9);
    tick();
    scramble();
    wait_valid("left.latency", 20);
    check("left.hcount", 32'(hcount_out), 0);
    check_out("left", 'hFF00, 'hFF57, 0, 0, 'h0100, 'h0183, 'h0080, 'h0060, 0, 0);
    retire("left");

    // Right edge: cameraX = 255
    drive(319, 16'h0380, 16'h0240, 16'hFF00, 16'h0000, 16'h0000, 16'h00A9);
    tick();
    scramble();
    wait_valid("right.latency", 20);
    check_out("right", 'hFF00, 'h00A8, 0, 1, 'h0100, 'h0186, 'h0080, 'h0124, 0, 0);
    retire("right");

    // Quotient saturation (|rayDir| = 1), most negative rayDir, rayDir clamp
    drive(160, 16'h0380, 16'h0240, 16'h0001, 16'h0000, 16'h0000, 16'h0000);
    tick();
    scramble();
    wait_valid("qsat.latency", 20);
    check_out("qsat", 1, 0, 1, 1, 'hFFFF, 'hFFFF, 'h7FFF, 'hBFFF, 0, 1);
    retire("qsat");

    drive(160, 16'h0380, 16'h0240, 16'h8000, 16'h0000, 16'h0000, 16'h0000);
    tick();
    scramble();
    wait_valid("mostneg.latency", 20);
    check_out("mostneg", 'h8000, 0, 0, 1, 'h0002, 'hFFFF, 'h0001, 'hBFFF, 0, 1);
    retire("mostneg");

    drive(319, 16'h0380, 16'h0240, 16'hFF00, 16'h7F00, 16'h0000, 16'h7F00);
    tick();
    scramble();
    wait_valid("rsat.latency", 20);
    check_out("rsat", 'hFF00, 'h7FFF, 0, 1, 'h0100, 'h0002, 'h0080, 'h0001, 0, 0);
    retire("rsat");

    // Backpressure, then both handshakes in the same cycle
    drive(160, 16'h0380, 16'h0240, 16'hFF00, 16'h0000, 16'h0000, 16'h00A9);
    tick();
    scramble();
    wait_valid("bp.latency", 20);
    for (int i = 0; i < 50; i++) begin
      tick();
      check("bp.out_valid", 32'(out_valid), 1);
      check("bp.in_ready", 32'(in_ready), 0);
      check("bp.hcount", 32'(hcount_out), 160);
      check_out("bp", 'hFF00, 0, 0, 1, 'h0100, 'hFFFF, 'h0080, 'hBFFF, 0, 1);
    end
    drive(0, 16'h0380, 16'h0240, 16'hFF00, 16'h0000, 16'h0000, 16'h00A9);
    out_ready = 1'b1;
    #1;
    check("b2b.in_ready", 32'(in_ready), 1);
    tick();
    scramble();
    out_ready = 1'b0;
    check("b2b.out_valid_drop", 32'(out_valid), 0);
    check("b2b.busy", 32'(busy), 1);
    wait_valid("b2b.latency", 20);
    check("b2b.hcount", 32'(hcount_out), 0);
    check_out("b2b", 'hFF00, 'hFF57, 0, 0, 'h0100, 'h0183, 'h0080, 'h0060, 0, 0);
    retire("b2b");

    // Asynchronous reset in the middle of the divide
    drive(160, 16'h0380, 16'h0240, 16'hFF00, 16'h0000, 16'h0000, 16'h00A9);
    tick();
    scramble();
    for (int i = 0; i < 11; i++) tick();
    #2;
    rst = 1'b1;
    #1;
    check_reset_state("midrst");
    tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (out_valid || busy) seen++;
    end
    check("midrst.no_stale", 32'(seen), 0);
    drive(160, 16'h0380, 16'h0240, 16'hFF00, 16'h0000, 16'h0000, 16'h00A9);
    tick();
    scramble();
    wait_valid("midrst.latency", 20);
    check("midrst.hcount", 32'(hcount_out), 160);
    check_out("after_rst", 'hFF00, 0, 0, 1, 'h0100, 'hFFFF, 'h0080, 'hBFFF, 0, 1);
    retire("after_rst");

    // Stream a full frame with the consumer always ready
    out_ready = 1'b1;
    fork
      begin
        for (int h = 0; h < 320; h++) begin
          drive(h, 16'h0380, 16'h0240, 16'hFF00, 16'h0000, 16'h0000, 16'h00A9);
          for (int k = 0; k < 100 && !in_ready; k++) tick();
          tick();
        end
        in_valid = 1'b0;
      end
      begin
        int got;
        exp_t m;
        got = 0;
        for (int c = 0; c < 320 * 25 && got < 320; c++) begin
          tick();
          if (out_valid) begin
            m = model(got, 'h0380, 'h0240, -256, 0, 0, 169);
            check("stream.hcount", 32'(hcount_out), 32'(got));
            check_out("stream", m.rx, m.ry, m.sx, m.sy, m.dx, m.dy, m.ex, m.ey, m.zx, m.zy);
            got++;
          end
        end
        check("stream.count", 32'(got), 320);
      end
    join
    out_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ray_setup_pipe.md
Name: ray_setup_pipe

Overview:
Parametrised successor to the per-column ray setup stage of the raycaster. For one screen column it computes cameraX, the ray direction, step signs, map cell, |1/rayDir| delta distances and the initial side distances. It uses a valid/ready handshake on both sides and holds a registered output until the DDA stage consumes it. Two internal iterative dividers (X and Y) run in parallel with a fixed latency, and saturate or flag divide-by-zero.

Parameters:
WIDTH, 16, total bits of every fixed-point value (signed two's complement where noted)
FBITS, 8, fraction bits (Q(WIDTH-FBITS).FBITS)
SCREEN_WIDTH, 320, columns per frame; hcount range 0..SCREEN_WIDTH-1
HCOUNT_W, 9, hcount width
MAP_W, 7, map coordinate width

Ports:
pixel_clk_in  in  1  clock
rst_in  in  1  reset, asynchronous, active-high
in_valid  in  1  request valid
in_ready  out  1  block can accept request
hcount_in  in  HCOUNT_W  column index
posX, posY  in  WIDTH  unsigned player position
dirX, dirY, planeX, planeY  in  WIDTH  signed direction / camera plane
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
hcount_out  out  HCOUNT_W  column of result
rayDirX, rayDirY  out  WIDTH  signed ray direction
stepX, stepY  out  1  1 = +1, 0 = -1
mapX, mapY  out  MAP_W  integer cell of pos
deltaDistX, deltaDistY  out  WIDTH  unsigned |1/rayDir|
sideDistX, sideDistY  out  WIDTH  unsigned initial side distance
dbzX, dbzY  out  1  rayDir component was zero
busy  out  1  request in flight or output held

Behaviour:
- Reset (async, any time, including mid-divide): all outputs 0 except in_ready=1. State returns to IDLE and the in-flight request is discarded with no out_valid pulse.
- States: IDLE -> RAYDIR -> DIVIDE -> SIDE -> HOLD -> IDLE.
- Acceptance: in_valid & in_ready on an edge. All inputs are registered; later input changes do not affect the result.
- in_ready=1 only in IDLE. In HOLD, in_ready=1 during the cycle out_ready=1, which allows back-to-back operation. If both handshakes fire in the same cycle, the new request goes to RAYDIR and the old result retires.
- RAYDIR (1 cycle):
  - cameraX = ((2*h - SCREEN_WIDTH) * CAM_K + 2^(FBITS-1)) >>> FBITS, with CAM_K = round(2^(2*FBITS)/SCREEN_WIDTH), a localparam.
  - rayDir = dir + ((plane*cameraX) >>> FBITS), saturated to the signed WIDTH range.
- Steps: step = ~rayDir[WIDTH-1]. Zero rayDir gives step=1.
- Map cell: map = pos[WIDTH-1:FBITS], truncated to MAP_W.
- DIVIDE (exactly 2*FBITS+1 cycles, both axes in lockstep): restoring divide, quotient = floor(2^(2*FBITS)/|rayDir|).
  - If the quotient exceeds 2^WIDTH-1, deltaDist = 2^WIDTH-1.
  - If |rayDir| = 0, deltaDist = 2^WIDTH-1 and dbz=1.
  - |most negative| is taken as 2^(WIDTH-1).
- SIDE (1 cycle), with f = pos[FBITS-1:0]:
  - step=0: side = (f * delta) >> FBITS.
  - step=1: side = ((2^FBITS - f) * delta) >> FBITS.
  - Both saturate to 2^WIDTH-1.
- HOLD: out_valid=1 and all outputs stable until out_ready. out_valid falls the cycle after acceptance unless a new result completes at the same time.
- Latency: out_valid rises exactly 2*FBITS+4 edges after acceptance (20 for the defaults).
- busy = (state != IDLE).

Test Plan:
- Centre column: posX=0x0380, posY=0x0240, dir=(0xFF00,0x0000), plane=(0x0000,0x00A9), h=160 -> rayDir=(0xFF00,0x0000), step=(0,1), map=(3,2), delta=(0x0100,0xFFFF), side=(0x0080,0xBFFF), dbz=(0,1); out_valid 20 cycles after acceptance.
- Same setup, h=0 -> cameraX=-256, rayDirY=0xFF57, stepY=0, deltaY=0x0183, sideY=0x0060. h=319 -> cameraX=255.
- Saturation: dirX=0x0001, plane=0, h=160 -> deltaX=0xFFFF, dbzX=0. dirX=0x8000 -> deltaX=0x0002.
- Backpressure: hold out_ready=0 for 50 cycles -> outputs stable, in_ready=0. Then pulse out_ready with in_valid=1 -> both handshakes in one cycle, next out_valid 20 cycles later.
- Reset at cycle 10 of DIVIDE -> all outputs 0, in_ready=1 asynchronously. No stale out_valid. The next request gives correct results.
- Stream columns 0..319 with out_ready=1 -> 320 results in order; hcount_out matches; stepY agrees with the sign of a software model; delta and side bit-exact with the model.
